fight_action_ctrl: RTL and testbench

// - Per-player action arbiter for the two-player fighting game; sits directly upstream of the animation/audio/score block.
// - Consumes the debounced active-low keys key_output[15:0] and that block's per-player animation-done strobes.
// - Drives its video/video_enable/audio/audio_enable/input_data inputs.
// - Resolves hits, guard and clash; tracks both player x-positions.

---
 rtl/fight_pkg.sv | 47 ++++
 rtl/fight_player_fsm.sv | 146 ++++++++++++++
 rtl/fight_action_ctrl.sv | 140 ++++++++++++++
 tb/tb_fight_action_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared constants for the fighting-game action controller: key bit
// positions inside a player's key byte, one-hot video/audio codes and the
// per-player FSM state encoding.
package fight_pkg;

  // Bit positions inside one player's active-low key byte
  localparam int KEY_FWD   = 0;
  localparam int KEY_GUARD = 1;
  localparam int KEY_LP    = 2;
  localparam int KEY_HP    = 3;
  localparam int KEY_LK    = 4;
  localparam int KEY_HK    = 5;
  localparam int KEY_JUMP  = 6;
  localparam int KEY_SKILL = 7;

  // One-hot per-player video action codes
  localparam logic [9:0] VID_NONE  = 10'h000;
  localparam logic [9:0] VID_MOVE  = 10'h001;
  localparam logic [9:0] VID_GUARD = 10'h002;
  localparam logic [9:0] VID_LP    = 10'h004;
  localparam logic [9:0] VID_HP    = 10'h008;
  localparam logic [9:0] VID_LK    = 10'h010;
  localparam logic [9:0] VID_HK    = 10'h020;
  localparam logic [9:0] VID_JUMP  = 10'h040;
  localparam logic [9:0] VID_HIT   = 10'h080;
  localparam logic [9:0] VID_SKILL = 10'h100;
  localparam logic [9:0] VID_SKHIT = 10'h200;

  // One-hot audio event codes (upper four bits unused)
  localparam logic [12:0] AUD_NONE  = 13'h0000;
  localparam logic [12:0] AUD_LP    = 13'h0001;
  localparam logic [12:0] AUD_HP    = 13'h0002;
  localparam logic [12:0] AUD_LK    = 13'h0004;
  localparam logic [12:0] AUD_HK    = 13'h0008;
  localparam logic [12:0] AUD_SKILL = 13'h0010;
  localparam logic [12:0] AUD_HIT   = 13'h0020;
  localparam logic [12:0] AUD_BLOCK = 13'h0040;
  localparam logic [12:0] AUD_JUMP  = 13'h0080;
  localparam logic [12:0] AUD_CLASH = 13'h0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

endpackage

// File: rtl/fight_player_fsm.sv
// One player's action channel: key decode, edge re-arming, IDLE/ACT/HIT
// state, skill cooldown and the stuck-animation timeout.
module fight_player_fsm
  import fight_pkg::*;
#(
  parameter logic [31:0] SKILL_CD = 32'd16_000_000,
  parameter logic [31:0] TIMEOUT  = 32'd12_000_000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  keys,
  input  logic        own_done,
  input  logic        opp_done,
  input  logic        hit_req,
  input  logic        hit_skill,
  output logic        go,
  output logic        go_skill,
  output logic        evt,
  output logic [12:0] evt_aud,
  output logic        is_idle,
  output logic        lvl_guard,
  output logic        lvl_jump,
  output logic        lvl_fwd,
  output logic [9:0]  vid,
  output logic        vid_en
);

  state_t      state_q, state_d;
  logic [9:0]  vid_q, vid_d;
  logic        en_q, en_d;
  logic        armed_q, armed_d;
  logic [31:0] cd_q, cd_d;
  logic [31:0] tmo_q, tmo_d;

  logic [7:0]  pressed;
  logic [9:0]  atk_vid, lvl_vid;
  logic [12:0] atk_aud;
  logic        atk_skill, jump_start, tmo_hit;

  // Decode the key byte into the highest-priority attack and level action
  always_comb begin
    pressed   = ~keys;
    atk_vid   = VID_NONE;
    atk_aud   = AUD_NONE;
    atk_skill = 1'b0;
    if (pressed[KEY_SKILL] && (cd_q == 32'd0)) begin
      atk_vid   = VID_SKILL;
      atk_aud   = AUD_SKILL;
      atk_skill = 1'b1;
    end else if (pressed[KEY_HP]) begin
      atk_vid = VID_HP;
      atk_aud = AUD_HP;
    end else if (pressed[KEY_HK]) begin
      atk_vid = VID_HK;
      atk_aud = AUD_HK;
    end else if (pressed[KEY_LP]) begin
      atk_vid = VID_LP;
      atk_aud = AUD_LP;
    end else if (pressed[KEY_LK]) begin
      atk_vid = VID_LK;
      atk_aud = AUD_LK;
    end
    if (pressed[KEY_JUMP])       lvl_vid = VID_JUMP;
    else if (pressed[KEY_GUARD]) lvl_vid = VID_GUARD;
    else if (pressed[KEY_FWD])   lvl_vid = VID_MOVE;
    else                         lvl_vid = VID_NONE;

    is_idle    = (state_q == ST_IDLE);
    go         = is_idle && armed_q && (atk_vid != VID_NONE);
    go_skill   = go && atk_skill;
    lvl_guard  = is_idle && (lvl_vid == VID_GUARD);
    lvl_jump   = is_idle && (lvl_vid == VID_JUMP);
    lvl_fwd    = is_idle && (lvl_vid == VID_MOVE);
    jump_start = lvl_jump && !go && (vid_q != VID_JUMP);
    evt        = go || jump_start;
    evt_aud    = go ? atk_aud : (jump_start ? AUD_JUMP : AUD_NONE);
    tmo_hit    = (tmo_q >= TIMEOUT);
  end

  // Next-state, video field, re-arm, cooldown and timeout computation
  always_comb begin
    state_d = state_q;
    vid_d   = vid_q;
    en_d    = 1'b0;
    armed_d = armed_q;
    cd_d    = (cd_q != 32'd0) ? cd_q - 32'd1 : 32'd0;
    tmo_d   = is_idle ? 32'd0 : tmo_q + 32'd1;
    if (keys == 8'hFF) armed_d = 1'b1;
    else if (go)       armed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_ACT;
          vid_d   = atk_vid;
          en_d    = 1'b1;
          if (atk_skill) cd_d = SKILL_CD;
        end else if (hit_req) begin
          state_d = ST_HIT;
          vid_d   = hit_skill ? VID_SKHIT : VID_HIT;
        end else begin
          vid_d = lvl_vid;
        end
      end
      ST_ACT: begin
        if (own_done || tmo_hit) begin
          state_d = ST_IDLE;
          vid_d   = VID_NONE;
        end
      end
      ST_HIT: begin
        // The hit animation runs on the attacker's channel
        if (opp_done || tmo_hit) begin
          state_d = ST_IDLE;
          vid_d   = VID_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vid_d   = VID_NONE;
      end
    endcase
  end

  // Register channel state and outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= ST_IDLE;
      vid_q   <= VID_NONE;
      en_q    <= 1'b0;
      armed_q <= 1'b1;
      cd_q    <= 32'd0;
      tmo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      vid_q   <= vid_d;
      en_q    <= en_d;
      armed_q <= armed_d;
      cd_q    <= cd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign vid    = vid_q;
  assign vid_en = en_q;

endmodule

// File: rtl/fight_action_ctrl.sv
// Two-player action arbiter: runs both player channels, resolves hits,
// guard and clash, tracks x-positions and drives audio and score pulses.
module fight_action_ctrl
  import fight_pkg::*;
#(
  parameter logic [9:0]  P1_START    = 10'd100,
  parameter logic [9:0]  P2_START    = 10'd500,
  parameter logic [9:0]  MIN_GAP     = 10'd40,
  parameter logic [9:0]  STEP        = 10'd4,
  parameter logic [31:0] MOVE_TICKS  = 32'd2_000_000,
  parameter logic [9:0]  RANGE_ATK   = 10'd60,
  parameter logic [9:0]  RANGE_SKL   = 10'd200,
  parameter logic [31:0] SKILL_CD    = 32'd16_000_000,
  parameter logic [31:0] AUDIO_TICKS = 32'd800_000,
  parameter logic [31:0] TIMEOUT     = 32'd12_000_000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] key_output,
  input  logic        busy_player1,
  input  logic        busy_player2,
  output logic [19:0] video,
  output logic        video_enable1,
  output logic        video_enable2,
  output logic [12:0] audio,
  output logic        audio_enable,
  output logic [7:0]  input_data,
  output logic [9:0]  pos1,
  output logic [9:0]  pos2
);

  logic        go1, go2, sk1, sk2, evt1, evt2, idle1, idle2;
  logic        grd1, grd2, jmp1, jmp2, fwd1, fwd2;
  logic [12:0] eaud1, eaud2;
  logic [9:0]  vid1, vid2;
  logic        hit_on1, hit_on2, blk_on1, blk_on2, reach1, reach2, clash;

  logic [9:0]  pos1_q, pos1_d, pos2_q, pos2_d;
  logic [12:0] aud_q, aud_d;
  logic        aen_q, aen_d;
  logic [31:0] acnt_q, acnt_d;
  logic [7:0]  score_q, score_d;
  logic [31:0] mcnt_q, mcnt_d;
  logic [9:0]  gap, slack, slack2, s1, s2;
  logic        mv_tick;

  fight_player_fsm #(.SKILL_CD(SKILL_CD), .TIMEOUT(TIMEOUT)) u_p1 (
    .clk(clk), .RST(RST), .keys(key_output[7:0]),
    .own_done(busy_player1), .opp_done(busy_player2),
    .hit_req(hit_on1), .hit_skill(sk2),
    .go(go1), .go_skill(sk1), .evt(evt1), .evt_aud(eaud1), .is_idle(idle1),
    .lvl_guard(grd1), .lvl_jump(jmp1), .lvl_fwd(fwd1),
    .vid(vid1), .vid_en(video_enable1)
  );

  fight_player_fsm #(.SKILL_CD(SKILL_CD), .TIMEOUT(TIMEOUT)) u_p2 (
    .clk(clk), .RST(RST), .keys(key_output[15:8]),
    .own_done(busy_player2), .opp_done(busy_player1),
    .hit_req(hit_on2), .hit_skill(sk1),
    .go(go2), .go_skill(sk2), .evt(evt2), .evt_aud(eaud2), .is_idle(idle2),
    .lvl_guard(grd2), .lvl_jump(jmp2), .lvl_fwd(fwd2),
    .vid(vid2), .vid_en(video_enable2)
  );

  // Hit / guard / clash resolution in the attacker's ACT-entry cycle
  always_comb begin
    gap     = pos2_q - pos1_q;
    clash   = go1 && go2;
    reach2  = go1 && !go2 && idle2 && (gap <= (sk1 ? RANGE_SKL : RANGE_ATK));
    reach1  = go2 && !go1 && idle1 && (gap <= (sk2 ? RANGE_SKL : RANGE_ATK));
    blk_on2 = reach2 && grd2;
    blk_on1 = reach1 && grd1;
    hit_on2 = reach2 && !grd2 && !(jmp2 && !sk1);
    hit_on1 = reach1 && !grd1 && !(jmp1 && !sk2);
    score_d = {4'b0000, hit_on1 && sk2, hit_on1 && !sk2, hit_on2 && sk1, hit_on2 && !sk1};
  end

  // Audio event arbitration and hold counter
  always_comb begin
    aud_d  = aud_q;
    aen_d  = aen_q;
    acnt_d = acnt_q;
    if (clash || hit_on1 || hit_on2 || blk_on1 || blk_on2 || evt1 || evt2) begin
      aen_d  = 1'b1;
      acnt_d = AUDIO_TICKS;
      if (clash)                   aud_d = AUD_CLASH;
      else if (hit_on1 || hit_on2) aud_d = AUD_HIT;
      else if (blk_on1 || blk_on2) aud_d = AUD_BLOCK;
      else if (evt1)               aud_d = eaud1;
      else                         aud_d = eaud2;
    end else if (acnt_q != 32'd0) begin
      acnt_d = acnt_q - 32'd1;
      if (acnt_q == 32'd1) begin
        aud_d = AUD_NONE;
        aen_d = 1'b0;
      end
    end
  end

  // Movement: free-running tick, P1 steps first, both clamped at MIN_GAP
  always_comb begin
    mv_tick = (mcnt_q == MOVE_TICKS - 32'd1);
    mcnt_d  = mv_tick ? 32'd0 : mcnt_q + 32'd1;
    slack   = gap - MIN_GAP;
    s1      = (mv_tick && fwd1 && !go1) ? ((slack < STEP) ? slack : STEP) : 10'd0;
    slack2  = slack - s1;
    s2      = (mv_tick && fwd2 && !go2) ? ((slack2 < STEP) ? slack2 : STEP) : 10'd0;
    pos1_d  = pos1_q + s1;
    pos2_d  = pos2_q - s2;
  end

  // Register positions, audio and score outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      pos1_q  <= P1_START;
      pos2_q  <= P2_START;
      aud_q   <= AUD_NONE;
      aen_q   <= 1'b0;
      acnt_q  <= 32'd0;
      score_q <= 8'h00;
      mcnt_q  <= 32'd0;
    end else begin
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      aud_q   <= aud_d;
      aen_q   <= aen_d;
      acnt_q  <= acnt_d;
      score_q <= score_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign video        = {vid2, vid1};
  assign audio        = aud_q;
  assign audio_enable = aen_q;
  assign input_data   = score_q;
  assign pos1         = pos1_q;
  assign pos2         = pos2_q;

endmodule

// File: tb/tb_fight_action_ctrl.sv
// Directed bench for fight_action_ctrl with small timing parameters.
// Expected values are queued as stimulus is applied and checked after the
// clock edge that should produce them.
module tb_fight_action_ctrl;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] key_output;
  logic        busy_player1, busy_player2;
  logic [19:0] video;
  logic        video_enable1, video_enable2;
  logic [12:0] audio;
  logic        audio_enable;
  logic [7:0]  input_data;
  logic [9:0]  pos1, pos2;

  int tests = 0;
  int fails = 0;

  localparam int S_V1 = 0, S_V2 = 1, S_VE1 = 2, S_VE2 = 3, S_AUD = 4;
  localparam int S_AEN = 5, S_DAT = 6, S_P1 = 7, S_P2 = 8, S_VID = 9;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fight_action_ctrl #(
    .MOVE_TICKS(32'd4), .AUDIO_TICKS(32'd8), .SKILL_CD(32'd50), .TIMEOUT(32'd100)
  ) dut (
    .clk(clk), .RST(RST), .key_output(key_output),
    .busy_player1(busy_player1), .busy_player2(busy_player2),
    .video(video), .video_enable1(video_enable1), .video_enable2(video_enable2),
    .audio(audio), .audio_enable(audio_enable), .input_data(input_data),
    .pos1(pos1), .pos2(pos2)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_V1:    return {22'd0, video[9:0]};
      S_V2:    return {22'd0, video[19:10]};
      S_VE1:   return {31'd0, video_enable1};
      S_VE2:   return {31'd0, video_enable2};
      S_AUD:   return {19'd0, audio};
      S_AEN:   return {31'd0, audio_enable};
      S_DAT:   return {24'd0, input_data};
      S_P1:    return {22'd0, pos1};
      S_P2:    return {22'd0, pos2};
      default: return {12'd0, video};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare with the DUT now
  task automatic check();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      tests++;
      assert (o === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
      $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, e.tag, o, e.exp);
    end
  endtask

  // Advance n clocks, ending at a falling edge where outputs are sampled
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_busy(input logic b1, input logic b2);
    busy_player1 = b1;
    busy_player2 = b2;
    step(1);
    busy_player1 = 1'b0;
    busy_player2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    key_output = 16'hFFFF;
    busy_player1 = 1'b0;
    busy_player2 = 1'b0;
    @(negedge clk);
    step(2);
    push("rst_video", S_VID, 32'h0);
    push("rst_aen", S_AEN, 32'h0);
    push("rst_data", S_DAT, 32'h0);
    push("rst_pos1", S_P1, 32'd100);
    push("rst_pos2", S_P2, 32'd500);
    check();
    RST = 1'b0;
    step(1);

    // P1 light punch with a 400 gap: action only, no score
    key_output = 16'hFFFB;
    push("lp_v1", S_V1, 32'h004);
    push("lp_v2", S_V2, 32'h000);
    push("lp_ve1", S_VE1, 32'h1);
    push("lp_aud", S_AUD, 32'h0001);
    push("lp_aen", S_AEN, 32'h1);
    push("lp_dat", S_DAT, 32'h0);
    step(1);
    check();
    key_output = 16'hFFFF;
    push("lp_ve1_pulse", S_VE1, 32'h0);
    push("lp_v1_held", S_V1, 32'h004);
    step(1);
    check();
    push("lp_aud_last", S_AUD, 32'h0001);
    step(6);
    check();
    push("lp_aud_off", S_AUD, 32'h0000);
    push("lp_aen_off", S_AEN, 32'h0);
    step(1);
    check();
    push("lp_done_v1", S_V1, 32'h000);
    pulse_busy(1'b1, 1'b0);
    check();

    // Both walk forward until the clamp holds them MIN_GAP apart
    key_output = 16'hFEFE;
    push("mv_v1", S_V1, 32'h001);
    push("mv_v2", S_V2, 32'h001);
    step(1);
    check();
    push("mv_pos1", S_P1, 32'd280);
    push("mv_pos2", S_P2, 32'd320);
    step(220);
    check();
    key_output = 16'hFFFF;
    push("mv_stop", S_VID, 32'h0);
    step(1);
    check();

    // P1 heavy punch in range: P2 takes a hit, P1 scores
    key_output = 16'hFFF7;
    push("hp_v1", S_V1, 32'h008);
    push("hp_v2", S_V2, 32'h080);
    push("hp_dat", S_DAT, 32'h01);
    push("hp_aud", S_AUD, 32'h0020);
    step(1);
    check();
    key_output = 16'hFFFF;
    push("hp_dat_pulse", S_DAT, 32'h00);
    push("hp_v2_held", S_V2, 32'h080);
    step(1);
    check();
    push("hp_done", S_VID, 32'h0);
    pulse_busy(1'b1, 1'b0);
    check();

    // P2 guards against P1 light kick
    key_output = 16'hFDFF;
    push("grd_v2", S_V2, 32'h002);
    step(1);
    check();
    key_output = 16'hFDEF;
    push("grd_v1", S_V1, 32'h010);
    push("grd_v2_kept", S_V2, 32'h002);
    push("grd_dat", S_DAT, 32'h00);
    push("grd_aud", S_AUD, 32'h0040);
    step(1);
    check();
    key_output = 16'hFFFF;
    pulse_busy(1'b1, 1'b0);
    push("grd_done", S_VID, 32'h0);
    step(1);
    check();

    // Simultaneous attacks clash
    key_output = 16'hF7FB;
    push("clash_v1", S_V1, 32'h004);
    push("clash_v2", S_V2, 32'h008);
    push("clash_ve2", S_VE2, 32'h1);
    push("clash_dat", S_DAT, 32'h00);
    push("clash_aud", S_AUD, 32'h0100);
    step(1);
    check();
    key_output = 16'hFFFF;
    step(1);
    push("clash_done", S_VID, 32'h0);
    pulse_busy(1'b1, 1'b1);
    check();

    // Skill in range gives a skill-hit, then the cooldown blocks a repeat
    key_output = 16'hFF7F;
    push("sk_v1", S_V1, 32'h100);
    push("sk_v2", S_V2, 32'h200);
    push("sk_dat", S_DAT, 32'h02);
    push("sk_aud", S_AUD, 32'h0020);
    step(1);
    check();
    key_output = 16'hFFFF;
    step(1);
    push("sk_done", S_VID, 32'h0);
    pulse_busy(1'b1, 1'b0);
    check();
    key_output = 16'hFF7F;
    push("cd_block_v1", S_V1, 32'h000);
    push("cd_block_ve1", S_VE1, 32'h0);
    step(1);
    check();
    key_output = 16'hFFFF;
    step(60);

    // After cooldown the skill works again; no done strobe -> timeout
    key_output = 16'hFF7F;
    push("cd_over_v1", S_V1, 32'h100);
    step(1);
    check();
    key_output = 16'hFFFF;
    push("tmo_wait_v1", S_V1, 32'h100);
    step(90);
    check();
    push("tmo_v1", S_V1, 32'h000);
    push("tmo_v2", S_V2, 32'h000);
    step(15);
    check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
